// File: rtl/vdivide_unit_iter.sv
// Iterative restoring integer divider for one vector lane: BPC quotient bits per cycle, with RVV
// divide-by-zero and signed-overflow results. Define VDIV_EARLY_OUT_EN to skip leading zeros.
module vdivide_unit_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] vs1_data,
    input  logic [WIDTH-1:0] vs2_data,
    input  logic [1:0]       sew,
    input  logic             div_type,
    input  logic             is_signed,
    input  logic             flush,
    output logic [WIDTH-1:0] wdata_du,
    output logic             busy_du,
    output logic             done_du,
    output logic             exception_du
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StPrep, StIter, StFin} state_e;

    state_e           state_q;
    logic [CW-1:0]    ew_q, cnt_q;
    logic [WIDTH-1:0] a_q, b_q, dvd_q, rem_q, dsr_q;
    logic             div_type_q, signed_q, q_neg_q, r_neg_q;

    function automatic logic [WIDTH-1:0] ew_mask(input logic [CW-1:0] ew);
        logic [WIDTH-1:0] m;
        if (ew >= CW'(WIDTH)) m = '1;
        else m = (WIDTH'(1) << ew) - WIDTH'(1);
        return m;
    endfunction

    // Truncate to ew bits, then sign- or zero-extend back to WIDTH.
    function automatic logic [WIDTH-1:0] ext_ew(input logic [WIDTH-1:0] v,
                                                input logic [CW-1:0] ew, input logic sgn);
        logic [WIDTH-1:0] m, top, r;
        m   = ew_mask(ew);
        top = m ^ (m >> 1);
        if (sgn && |(v & top)) r = v | ~m;
        else r = v & m;
        return r;
    endfunction

    logic [6:0]    ew_raw;
    logic [CW-1:0] ew_in;

    always_comb begin
        ew_raw = 7'd8 << sew;
        ew_in  = (ew_raw > 7'(WIDTH)) ? CW'(WIDTH) : CW'(ew_raw);
    end

    logic [WIDTH-1:0] mask, top, a_m, b_m, a_abs, b_abs, dvd_init, spec_q, spec_r, spec_res;
    logic             a_neg, b_neg, div_zero, ovf, zero_dvd, special;
    logic [CW-1:0]    cnt_init, nbits;
`ifdef VDIV_EARLY_OUT_EN
    logic [CW-1:0]    sig;
    logic [CW:0]      sig_p1;
`endif

    always_comb begin
        mask     = ew_mask(ew_q);
        top      = mask ^ (mask >> 1);
        a_m      = a_q & mask;
        b_m      = b_q & mask;
        a_neg    = signed_q && |(a_m & top);
        b_neg    = signed_q && |(b_m & top);
        a_abs    = a_neg ? ((~a_m + WIDTH'(1)) & mask) : a_m;
        b_abs    = b_neg ? ((~b_m + WIDTH'(1)) & mask) : b_m;
        div_zero = (b_m == '0);
        ovf      = signed_q && (a_m == top) && (b_m == mask);
`ifdef VDIV_EARLY_OUT_EN
        sig = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (a_abs[i]) sig = CW'(i + 1);
        end
        sig_p1   = {1'b0, sig} + (CW+1)'(1);
        cnt_init = (BPC == 2) ? sig_p1[CW:1] : sig;
        nbits    = (BPC == 2) ? (cnt_init << 1) : cnt_init;
        zero_dvd = (a_abs == '0);
`else
        cnt_init = (BPC == 2) ? (ew_q >> 1) : ew_q;
        nbits    = ew_q;
        zero_dvd = 1'b0;
`endif
        // Park the significant dividend bits at the top so quotient bits land in the low end.
        dvd_init = a_abs << (CW'(WIDTH) - nbits);
        special  = div_zero | ovf | zero_dvd;
        if (div_zero) begin
            spec_q = '1;
            spec_r = a_q;
        end else if (ovf) begin
            spec_q = a_q;
            spec_r = '0;
        end else begin
            spec_q = '0;
            spec_r = '0;
        end
        spec_res = ext_ew(div_type_q ? spec_r : spec_q, ew_q, signed_q);
    end

    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_nx, d_nx, q_fin, r_fin, fin_res;

    always_comb begin
        t    = '0;
        r_nx = rem_q;
        d_nx = dvd_q;
        for (int i = 0; i < int'(BPC); i++) begin
            t    = {r_nx, d_nx[WIDTH-1]};
            d_nx = {d_nx[WIDTH-2:0], 1'b0};
            if (t >= {1'b0, dsr_q}) begin
                t       = t - {1'b0, dsr_q};
                d_nx[0] = 1'b1;
            end
            r_nx = t[WIDTH-1:0];
        end
        q_fin   = q_neg_q ? -d_nx : d_nx;
        r_fin   = r_neg_q ? -r_nx : r_nx;
        fin_res = ext_ew(div_type_q ? r_fin : q_fin, ew_q, signed_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            ew_q       <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            div_type_q <= 1'b0;
            signed_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            wdata_du   <= '0;
            busy_du    <= 1'b0;
            done_du    <= 1'b0;
        end else begin
            done_du <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                busy_du <= 1'b0;
            end else begin
                case (state_q)
                    // The done cycle (StFin) accepts a new start just like idle.
                    StIdle, StFin: begin
                        if (start) begin
                            a_q        <= vs2_data;
                            b_q        <= vs1_data;
                            ew_q       <= ew_in;
                            div_type_q <= div_type;
                            signed_q   <= is_signed;
                            busy_du    <= 1'b1;
                            state_q    <= StPrep;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StPrep: begin
                        q_neg_q <= a_neg ^ b_neg;
                        r_neg_q <= a_neg;
                        dsr_q   <= b_abs;
                        rem_q   <= '0;
                        dvd_q   <= dvd_init;
                        cnt_q   <= cnt_init;
                        if (special) begin
                            wdata_du <= spec_res;
                            done_du  <= 1'b1;
                            busy_du  <= 1'b0;
                            state_q  <= StFin;
                        end else begin
                            state_q <= StIter;
                        end
                    end
                    StIter: begin
                        rem_q <= r_nx;
                        dvd_q <= d_nx;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            wdata_du <= fin_res;
                            done_du  <= 1'b1;
                            busy_du  <= 1'b0;
                            state_q  <= StFin;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign exception_du = 1'b0;

endmodule

// File: tb/tb_vdivide_unit_iter.sv
// Self-checking bench for vdivide_unit_iter: directed vector table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model (WIDTH=32/BPC=1, WIDTH=64/BPC=2).
module tb_vdivide_unit_iter;
`ifdef VDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32, start64, div_type, is_signed, flush;
    logic [63:0] vs1, vs2;
    logic [1:0]  sew;
    logic [31:0] wdata32;
    logic        busy32, done32, exc32;
    logic [63:0] wdata64;
    logic        busy64, done64, exc64;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    vdivide_unit_iter #(.WIDTH(32), .BPC(1)) dut (
        .CLK(clk), .RST(rst), .start(start32), .vs1_data(vs1[31:0]), .vs2_data(vs2[31:0]),
        .sew(sew), .div_type(div_type), .is_signed(is_signed), .flush(flush),
        .wdata_du(wdata32), .busy_du(busy32), .done_du(done32), .exception_du(exc32)
    );

    vdivide_unit_iter #(.WIDTH(64), .BPC(2)) dut64 (
        .CLK(clk), .RST(rst), .start(start64), .vs1_data(vs1), .vs2_data(vs2),
        .sew(sew), .div_type(div_type), .is_signed(is_signed), .flush(flush),
        .wdata_du(wdata64), .busy_du(busy64), .done_du(done64), .exception_du(exc64)
    );

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  s;
        logic        dt;
        logic        sg;
    } op_t;

    typedef struct {
        op_t         op;
        logic [63:0] exp;
        int          lat_fix;
        int          lat_eo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic on ew-bit operands with RVV special cases.
    function automatic logic [63:0] ref_res(input op_t op, input int width);
        int          ew;
        logic [63:0] mask, top, ua, ub, q, r, v;
        longint      sa, sb;
        ew   = 8 << op.s;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        top  = 64'd1 << (ew - 1);
        ua   = op.a & mask;
        ub   = op.b & mask;
        sa   = longint'((ua ^ top) - top);
        sb   = longint'((ub ^ top) - top);
        if (ub == 0) begin
            q = mask;
            r = ua;
        end else if (op.sg && ua == top && ub == mask) begin
            q = ua;
            r = 64'd0;
        end else if (op.sg) begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        v = (op.dt ? r : q) & mask;
        if (op.sg && (v & top) != 0) v = v | ~mask;
        if (width == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic int ref_lat(input op_t op, input int bpc);
        int          ew;
        logic [63:0] mask, top, ua, ub, mag;
        longint      sa;
        int          nb;
        ew   = 8 << op.s;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        top  = 64'd1 << (ew - 1);
        ua   = op.a & mask;
        ub   = op.b & mask;
        sa   = longint'((ua ^ top) - top);
        if (ub == 0) return 2;
        if (op.sg && ua == top && ub == mask) return 2;
        mag = (op.sg && sa < 0) ? 64'(-sa) : ua;
        nb  = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) nb = i + 1;
        if (EO) begin
            if (mag == 0) return 2;
            return (nb + bpc - 1) / bpc + 2;
        end
        return ew / bpc + 2;
    endfunction

    function automatic op_t rand_op(input bit wide);
        op_t op;
        op.s  = wide ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        op.a  = {$urandom, $urandom};
        op.b  = {$urandom, $urandom} >> $urandom_range(0, 63);
        op.dt = 1'($urandom);
        op.sg = 1'($urandom);
        case ($urandom_range(0, 7))
            0: op.b = 64'd0;
            1: begin op.a = 64'd1 << ((8 << op.s) - 1); op.b = '1; end
            2: op.a = op.a >> $urandom_range(0, 63);
            default: ;
        endcase
        return op;
    endfunction

    function automatic vec_t mk(input logic [63:0] a, b, input logic [1:0] s, input logic dt, sg,
                                input logic [63:0] exp, input int lf, le);
        vec_t v;
        v.op      = '{a: a, b: b, s: s, dt: dt, sg: sg};
        v.exp     = exp;
        v.lat_fix = lf;
        v.lat_eo  = le;
        return v;
    endfunction

    // Launch one op (start sampled at "cycle 0" edge); return result and done cycle (-1 on timeout).
    // Optional extra start pulse in cycle poke_cyc. Inputs are scrambled right after launch.
    task automatic run_op(input op_t op, input bit wide, input int poke_cyc,
                          output logic [63:0] res, output int lat, output bit busy_ok);
        @(negedge clk);
        vs2 = op.a; vs1 = op.b; sew = op.s; div_type = op.dt; is_signed = op.sg;
        if (wide) start64 = 1'b1;
        else start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0; start64 = 1'b0;
        vs2 = {$urandom, $urandom}; vs1 = {$urandom, $urandom};
        div_type = 1'($urandom); is_signed = 1'($urandom);
        sew = wide ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        lat = -1; busy_ok = 1'b1; res = '0;
        for (int c = 1; c <= 200; c++) begin
            if (wide ? done64 : done32) begin
                lat = c;
                res = wide ? wdata64 : {32'h0, wdata32};
                if (wide ? busy64 : busy32) busy_ok = 1'b0;
                break;
            end
            if (!(wide ? busy64 : busy32)) busy_ok = 1'b0;
            if (c == poke_cyc) begin
                if (wide) start64 = 1'b1;
                else start32 = 1'b1;
            end
            @(posedge clk); #1;
            start32 = 1'b0; start64 = 1'b0;
        end
    endtask

    vec_t        vecs[13];
    logic [63:0] res, last_exp;
    int          lat;
    bit          bok, seen;
    op_t         op;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(64'd100, 64'd7, 2'd2, 1'b0, 1'b0, 64'd14, 34, 9);
        vecs[1]  = mk(64'd100, 64'd7, 2'd2, 1'b1, 1'b0, 64'd2, 34, 9);
        vecs[2]  = mk(64'hF9, 64'h02, 2'd0, 1'b0, 1'b1, 64'hFFFF_FFFD, 10, 5);
        vecs[3]  = mk(64'hF9, 64'h02, 2'd0, 1'b1, 1'b1, 64'hFFFF_FFFF, 10, 5);
        vecs[4]  = mk(64'h1234, 64'h0, 2'd1, 1'b0, 1'b0, 64'h0000_FFFF, 2, 2);
        vecs[5]  = mk(64'h1234, 64'h0, 2'd1, 1'b1, 1'b0, 64'h0000_1234, 2, 2);
        vecs[6]  = mk(64'h8000_0000, 64'hFFFF_FFFF, 2'd2, 1'b0, 1'b1, 64'h8000_0000, 2, 2);
        vecs[7]  = mk(64'h8000_0000, 64'hFFFF_FFFF, 2'd2, 1'b1, 1'b1, 64'h0, 2, 2);
        vecs[8]  = mk(64'd5, 64'd1, 2'd2, 1'b0, 1'b0, 64'd5, 34, 5);
        vecs[9]  = mk(64'h8000, 64'h3, 2'd1, 1'b0, 1'b1, 64'hFFFF_D556, 18, 18);
        vecs[10] = mk(64'h8000, 64'h3, 2'd1, 1'b1, 1'b1, 64'hFFFF_FFFE, 18, 18);
        vecs[11] = mk(64'd7, 64'hFFFF_FFFE, 2'd2, 1'b1, 1'b1, 64'd1, 34, 5);
        vecs[12] = mk(64'hABCD_00C8, 64'h1234_5603, 2'd0, 1'b0, 1'b0, 64'h42, 10, 10);

        start32 = 1'b0; start64 = 1'b0; flush = 1'b0;
        vs1 = '0; vs2 = '0; sew = 2'd0; div_type = 1'b0; is_signed = 1'b0;

        #12;
        check("reset wdata", 64'(wdata32), 64'd0);
        check("reset busy", 64'(busy32), 64'd0);
        check("reset done", 64'(done32), 64'd0);
        check("reset exception", 64'(exc32), 64'd0);
        check("reset wdata64", wdata64, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; consecutive entries start in the previous done cycle.
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, 1'b0, 0, res, lat, bok);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 64'(lat),
                  64'(EO ? vecs[i].lat_eo : vecs[i].lat_fix));
            check($sformatf("vec%0d busy", i), 64'(bok), 64'd1);
        end

        // Extra start in cycle 5 ignored; then a start in the done cycle is accepted.
        op = '{a: 64'hF000_0000, b: 64'd7, s: 2'd2, dt: 1'b0, sg: 1'b0};
        run_op(op, 1'b0, 5, res, lat, bok);
        check("poke result", res, ref_res(op, 32));
        check("poke latency", 64'(lat), 64'd34);
        check("poke busy", 64'(bok), 64'd1);
        op.dt = 1'b1;
        run_op(op, 1'b0, 0, res, lat, bok);
        check("b2b result", res, ref_res(op, 32));
        check("b2b latency", 64'(lat), 64'd34);
        last_exp = ref_res(op, 32);

        // Flush in cycle 10: no done, busy low from cycle 11, wdata unchanged.
        @(negedge clk);
        vs2 = 64'hF000_0000; vs1 = 64'd3; sew = 2'd2; div_type = 1'b0; is_signed = 1'b0;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("flush busy before", 64'(busy32), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush busy after", 64'(busy32), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done32) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush no done", 64'(seen), 64'd0);
        check("flush wdata hold", 64'(wdata32), last_exp);

        // Asynchronous reset mid-iteration (cycle 15).
        @(negedge clk);
        vs2 = 64'hF000_0000; vs1 = 64'd5; sew = 2'd2; div_type = 1'b0; is_signed = 1'b0;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        check("pre-rst busy", 64'(busy32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst wdata", 64'(wdata32), 64'd0);
        check("rst busy", 64'(busy32), 64'd0);
        check("rst done", 64'(done32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        op = '{a: 64'd9, b: 64'd3, s: 2'd2, dt: 1'b0, sg: 1'b0};
        run_op(op, 1'b0, 0, res, lat, bok);
        check("post-rst result", res, 64'd3);
        check("post-rst latency", 64'(lat), 64'(EO ? 6 : 34));

        // WIDTH=64, BPC=2.
        op = '{a: 64'h8000_0000_0000_0000, b: 64'd3, s: 2'd3, dt: 1'b0, sg: 1'b0};
        run_op(op, 1'b1, 0, res, lat, bok);
        check("w64 result", res, 64'h2AAA_AAAA_AAAA_AAAA);
        check("w64 latency", 64'(lat), 64'd34);
        check("w64 busy", 64'(bok), 64'd1);

        for (int i = 0; i < 60; i++) begin
            op = rand_op(1'b0);
            run_op(op, 1'b0, 0, res, lat, bok);
            check($sformatf("rand32 %0d result a=%h b=%h", i, op.a, op.b), res, ref_res(op, 32));
            check($sformatf("rand32 %0d latency", i), 64'(lat), 64'(ref_lat(op, 1)));
        end
        for (int i = 0; i < 30; i++) begin
            op = rand_op(1'b1);
            run_op(op, 1'b1, 0, res, lat, bok);
            check($sformatf("rand64 %0d result a=%h b=%h", i, op.a, op.b), res, ref_res(op, 64));
            check($sformatf("rand64 %0d latency", i), 64'(lat), 64'(ref_lat(op, 2)));
        end
        check("exception64", 64'(exc64), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
